// File: rtl/axis_downsizer.sv
// Serializes one wide AXI-Stream beat into RATIO narrow beats, low or high slice first.
// Latency: first narrow beat is valid the cycle after the wide beat is accepted; no bubbles between words.
// Backpressure: wide tready rises only when empty or when the last slice is handshaking.
module axis_downsizer #(
    parameter int RATIO     = 4,
    parameter bit LSB_FIRST = 1'b1,
    parameter int NW        = 8,
    parameter int WW        = NW * RATIO
) (
    input  logic          clk,
    input  logic          rst,
    output logic          axis_mif_tvalid,
    output logic [NW-1:0] axis_mif_tdata,
    input  logic          axis_mif_tready,
    input  logic          axis_sif_tvalid,
    input  logic [WW-1:0] axis_sif_tdata,
    output logic          axis_sif_tready,
    input  logic          invalidate
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    generate
        if (RATIO < 2) begin : g_bad_ratio
            $fatal(1, "axis_downsizer: RATIO must be at least 2");
        end
        if (NW <= 0) begin : g_bad_nw
            $fatal(1, "axis_downsizer: narrow width must be positive");
        end
        if (WW != RATIO * NW) begin : g_bad_ww
            $fatal(1, "axis_downsizer: wide width must equal RATIO * narrow width");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   buf_q, buf_d;
    logic            tvalid_q;
    logic            last;
    logic            m_hs;
    logic            s_hs;
    logic [CW-1:0]   idx;
    logic [NW-1:0]   slice;

    assign tvalid_q = (state_q == SEND);
    assign last     = (cnt_q == LAST_IDX);
    assign m_hs     = tvalid_q && axis_mif_tready;

    // Accepting on the last-slice handshake is what keeps the narrow side gap-free.
    assign axis_sif_tready = !rst && !invalidate && (!tvalid_q || (axis_mif_tready && last));
    assign s_hs            = axis_sif_tvalid && axis_sif_tready;

    always_comb begin
        idx = LSB_FIRST ? cnt_q : (LAST_IDX - cnt_q);
    end

    always_comb begin
        slice = buf_q[int'(idx) * NW +: NW];
    end

    assign axis_mif_tvalid = !rst && tvalid_q;
    assign axis_mif_tdata  = rst ? '0 : slice;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (invalidate) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end else if (s_hs) begin
            buf_d   = axis_sif_tdata;
            cnt_d   = '0;
            state_d = SEND;
        end else if (m_hs && !last) begin
            cnt_d   = cnt_q + 1'b1;
        end else if (m_hs && last) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: doc/axis_downsizer.md
Name: axis_downsizer

Overview:
- AXI-Stream width downsizer (serializer). Accepts one wide beat on the subordinate side and emits RATIO narrow beats on the manager side, least-significant slice first.
- It is the transmit-side counterpart to an upsizer/deserializer. It sits between wide datapath FIFOs and narrow consumers such as byte-wide peripherals or narrow interconnect ports.
- It holds exactly one wide word and supports full back-to-back throughput.

Parameters:
- RATIO, 4, number of narrow beats per wide beat; must be ≥2.
- LSB_FIRST, 1, 1 = emit slice 0 (bits [NW-1:0]) first; 0 = emit the most-significant slice first.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- axis_mif  axis_if.m  NW = axis_mif.TDATA_WIDTH  narrow manager output (tvalid, tdata out; tready in).
- axis_sif  axis_if.s  WW = axis_sif.TDATA_WIDTH  wide subordinate input (tvalid, tdata in; tready out).
- invalidate  input  1  flush the held word; drops any unsent narrow beats.

Behaviour:
- Elaboration checks (fatal on failure): RATIO ≥ 2; WW == RATIO*NW; NW > 0.
- State:
  - buf_q [WW-1:0]: held wide word.
  - cnt_q [$clog2(RATIO)-1:0]: index of the current slice.
  - tvalid_q: a narrow beat is pending. tvalid_q=0 is EMPTY; tvalid_q=1 is SEND.
- Reset (rst=1 at a clock edge): tvalid_q=0, cnt_q=0, buf_q=0.
- While rst is high: axis_mif.tvalid=0, axis_mif.tdata=0, axis_sif.tready=0.
- Derived signals:
  - last = (cnt_q == RATIO-1).
  - m_hs = tvalid_q && axis_mif.tready.
  - s_hs = axis_sif.tvalid && axis_sif.tready.
- Outputs:
  - axis_mif.tvalid = tvalid_q.
  - axis_mif.tdata = buf_q slice idx, i.e. bits [idx*NW +: NW]. idx = cnt_q when LSB_FIRST=1; idx = RATIO-1-cnt_q when LSB_FIRST=0. The slice mux uses registered state only.
  - axis_sif.tready = !rst && !invalidate && (!tvalid_q || (axis_mif.tready && last)). This is the only combinational mif→sif path, and it is intentional so that back-to-back throughput is sustained.
- Next-state priority, highest first:
  1. invalidate=1: tvalid_q←0, cnt_q←0, buf_q unchanged. If a manager handshake occurs in this same cycle, that beat counts as delivered. No subordinate handshake can occur, because tready is forced to 0.
  2. s_hs: buf_q←axis_sif.tdata, cnt_q←0, tvalid_q←1. This is legal from EMPTY, or from SEND with m_hs && last.
  3. m_hs && !last: cnt_q←cnt_q+1.
  4. m_hs && last with no s_hs: tvalid_q←0, cnt_q←0.
  5. Otherwise hold all state.
- AXIS rules:
  - Once tvalid_q=1, axis_mif.tdata and tvalid stay stable until m_hs. The only exceptions are invalidate and rst.
  - tvalid never depends combinationally on tready.
- Latency and throughput:
  - A wide beat accepted at edge N produces its first narrow beat valid in cycle N+1.
  - With tready held at 1 on both sides, the output is continuous: RATIO narrow beats per wide beat with zero bubbles.
  - axis_sif.tready pulses once every RATIO cycles.
- Boundaries:
  - Manager stalls on the last slice: tvalid stays high, axis_sif.tready=0, the next wide word waits.
  - Manager stalls mid-word: cnt_q holds.
  - cnt_q wraps only through the s_hs or empty path; it never wraps by increment.
  - invalidate while EMPTY: no effect.
  - rst mid-word: unsent slices are discarded; after reset the first beat out is slice 0 of the next accepted word.

Test Plan (NW=8, WW=32, RATIO=4, LSB_FIRST=1 unless stated):
- Single word: push 0xDDCCBBAA with mif tready=1 → mif beats 0xAA, 0xBB, 0xCC, 0xDD on consecutive cycles starting 1 cycle after acceptance; then tvalid=0.
- Back-to-back: sif tvalid=1 with 0x04030201 then 0x08070605, mif tready=1 → 8 consecutive beats 01..08, no bubble; sif tready high exactly on the cycles where beats 04 and 08 are sent (and before the first word).
- Backpressure: same word, mif tready toggles 1,0,0,1,1,0,1 → beats AA, BB, CC, DD delivered in order; tdata stable while tready=0; sif tready=0 until DD handshakes.
- LSB_FIRST=0: push 0x11223344 → beats 0x11, 0x22, 0x33, 0x44.
- Invalidate: push 0xDDCCBBAA, take AA, assert invalidate for 1 cycle with mif tready=0 → next cycle tvalid=0; sif tready=0 during the invalidate cycle; a subsequent push of 0x00000055 yields first beat 0x55.
- Reset mid-word: after AA is taken, rst=1 for 2 cycles → tvalid=0 and sif tready=0 during rst; after rst drops, tvalid=0 and sif tready=1; push 0x44332211 → beat 0x11 first.
